// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word reads to
// instruction memory over req/gnt/rvalid, buffers returned words with their
// PC in a small FIFO and hands them to decode over valid/ready. A redirect
// flushes the buffer and drops every response still owed to older requests.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        fifo_q [FIFO_DEPTH];

    logic [CW+1:0] credit_used;
    logic          issue;
    logic          resp_any;
    logic          resp_drop;
    logic          resp_keep;
    logic          push;
    logic          pop;
    entry_t        head;
    logic [31:0]   redirect_pc_aligned;
    logic          redirect_pc_lsb_unused;

    // Low address bits of the redirect target are deliberately ignored.
    assign redirect_pc_aligned    = {redirect_pc[31:2], 2'b00};
    assign redirect_pc_lsb_unused = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every request in flight or being discarded already owns a FIFO slot, so
    // responses can never overflow the buffer and rvalid needs no backpressure.
    assign credit_used = {2'b00, inflight_q} + {2'b00, discard_q} + {2'b00, count_q};
    assign imem_req    = rst_n && !redirect && (credit_used < (CW+2)'(FIFO_DEPTH));
    assign imem_addr   = pc_q;
    assign issue       = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_any  = imem_rvalid && ((inflight_q != '0) || (discard_q != '0));
    assign resp_drop = resp_any && (discard_q != '0);
    assign resp_keep = resp_any && (discard_q == '0);
    assign push      = resp_keep && !redirect;

    assign head       = fifo_q[rd_ptr_q];
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? head.word : NOP;
    assign inst_pc    = inst_valid ? head.pc : last_pc_q;
    assign pop        = inst_valid && inst_ready && !redirect;

    // Next-state logic for PC, credit counters and FIFO bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        last_pc_d  = inst_valid ? head.pc : last_pc_q;

        if (redirect) begin
            // Everything owed to older requests is dropped; a response arriving
            // this same cycle settles one of those debts immediately.
            pc_d       = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            inflight_d = '0;
            discard_d  = discard_q + inflight_q - CW'(resp_any);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            inflight_d = inflight_q + CW'(issue) - CW'(resp_keep);
            discard_d  = discard_q - CW'(resp_drop);
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the same pre-edge values.
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            last_pc_q  <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage: accepted responses are written at the tail with their PC.
    always_ff @(posedge clk) begin
        // NOTE: the storage is cleared on reset as well, so a stale word can
        // never be observed even if the pointer logic is later changed.
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, word: imem_rdata};
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage: a fixed-latency in-order memory model
// returns addr ^ 32'hA5A5_0000, and every word popped by decode is checked
// against the PC sequence the bench expects.
module tb_inst_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          lat;
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          npops;
    logic [31:0] exp_pc;

    inst_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: score any pop, advance, then drive the memory response.
    task automatic cycle();
        logic        issued;
        logic [31:0] a;
        mreq_t       r;
        issued = imem_req && imem_gnt;
        a      = imem_addr;
        if (rst_n && inst_valid && inst_ready && !redirect) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            npops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (imem_rvalid && mq.size() > 0) mq.delete(0);
        if (issued) begin
            r.addr = a;
            r.due  = cyc - 1 + lat;
            mq.push_back(r);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        inst_ready  = 1'b0;
        imem_rvalid = 1'b0;
        mq.delete();
        repeat (2) cycle();
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        npops  = 0;
        #1;
    endtask

    task automatic run_pops(input int target, input int budget);
        int n;
        n = 0;
        while (npops < target && n < budget) begin
            cycle();
            n++;
        end
        check("pop_count", 32'(npops), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        npops       = 0;
        cyc         = 0;
        lat         = 1;
        exp_pc      = 32'h0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // 1: reset state and first request after release
        repeat (3) cycle();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_req", {31'b0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);

        // 2: streaming, one instruction per cycle from the third cycle
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stream_valid", {31'b0, inst_valid}, (i >= 2) ? 32'd1 : 32'd0);
            cycle();
        end
        check("stream_pops", 32'(npops), 32'd8);

        // 3: backpressure fills buffer, request drops at credit limit
        do_reset();
        imem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_req", {31'b0, imem_req}, (i < 4) ? 32'd1 : 32'd0);
            if (i >= 2) check("bp_head", inst_pc, 32'h0);
            cycle();
        end
        check("bp_nopop", 32'(npops), 32'd0);
        inst_ready = 1'b1;
        run_pops(4, 20);

        // 4: grant stall holds address stable
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h10) break;
            cycle();
        end
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'b0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, 32'h10);
            cycle();
        end
        check("stall_drained", {31'b0, inst_valid}, 32'd0);
        check("stall_pops", 32'(npops), 32'd4);
        imem_gnt = 1'b1;
        run_pops(5, 10);

        // 5: redirect with two responses in flight on a 3-cycle memory
        do_reset();
        lat        = 3;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        exp_pc      = 32'h40;
        #1;
        check("rd_req_low", {31'b0, imem_req}, 32'd0);
        cycle();
        redirect = 1'b0;
        #1;
        check("rd_addr", imem_addr, 32'h40);
        check("rd_req", {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("rd_empty", {31'b0, inst_valid}, 32'd0);
            cycle();
        end
        check("rd_nostale", 32'(npops), 32'd0);
        run_pops(1, 5);

        // 6: redirect, rvalid and pop all in the same cycle
        do_reset();
        lat        = 1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (4) cycle();
        check("sim_valid", {31'b0, inst_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        exp_pc      = 32'h100;
        #1;
        cycle();
        redirect = 1'b0;
        #1;
        check("sim_addr", imem_addr, 32'h100);
        check("sim_empty", {31'b0, inst_valid}, 32'd0);
        run_pops(3, 10);

        // 7: PC wraps past 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        exp_pc      = 32'hFFFF_FFFC;
        #1;
        cycle();
        redirect = 1'b0;
        #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr2", imem_addr, 32'h0);
        run_pops(npops + 2, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
